reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file with same-cycle write bypass and a per-register pending-write scoreboard, for the pipelined core. Decode reads operands and reserves its destination; writeback writes data and clears the reservation. Hazard logic uses the busy flags to decide stalls. Register 0 is hardwired to zero and never becomes busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), register address width (derived, not overridden)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NRD×AW  read port addresses
- rd_data  out  NRD×XLEN  read data, combinational, bypassed
- rd_busy  out  NRD  read register has an outstanding reservation
- resv_en  in  1  reserve resv_addr (instruction issued with a destination)
- resv_addr  in  AW  register to mark busy
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- flush  in  1  drop all reservations (pipeline squash)
- busy_vec  out  NREGS  registered busy flags, bit 0 always 0

## Operation
- Storage: NREGS×XLEN flops. Index 0 is constant zero and has no storage write path.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data. When wr_addr=0, the write is ignored.
- Read, per port p: if wr_en and wr_addr=rd_addr[p]≠0, then rd_data[p]=wr_data (bypass). Otherwise rd_data[p]=reg[rd_addr[p]]. rd_addr=0 always returns 0.
- Busy update, per register r≠0, next state in priority order:
  - flush → 0
  - resv_en and resv_addr=r → 1
  - wr_en and wr_addr=r → 0
  - else hold
- Consequences:
  - Reserve and write to the same register in one cycle: stays busy, because a new producer supersedes the old one.
  - Flush beats reserve.
  - Flush does not block a data write in the same cycle.
  - Reserving an already-busy register keeps it busy (no counting).
  - Writing a non-busy register is legal. Data is written and the register stays 0/not busy.
- rd_busy[p] = busy[rd_addr[p]] AND NOT (wr_en AND wr_addr=rd_addr[p]). A producer completing this cycle is bypassed, not stalled. rd_busy for address 0 is 0.
- resv_addr=0 is ignored.

## Timing
- Reset (rst=0, asynchronous): all registers 0 and all busy flags 0. Therefore rd_data=0, rd_busy=0, busy_vec=0 while in reset and on release.
- Reset asserted mid-operation clears everything immediately, with no pending write preserved.
- Write latency: data is visible through storage on the cycle after the edge. It is visible the same cycle through bypass.
- Reservation latency: busy_vec and rd_busy reflect resv_en one cycle after the edge. In the reserving cycle itself, rd_busy does not reflect the new reservation; hazard logic compares against resv_addr itself.
- rd_data and rd_busy are purely combinational from rd_addr, wr_* and state. busy_vec is a direct flop output.

## Structure
- Package regfile_pkg: default XLEN/NREGS/NRD constants, typedef for the register address (logic [AW-1:0]) and the data word (logic [XLEN-1:0]).
- Sub-module reg_scoreboard owns the NREGS busy flops and their priority update.
- Top-level reg_file_sb owns storage, read muxes, bypass and rd_busy gating.
- Read ports are generated with a loop over NRD.

## Test plan
- Reset: write 0xDEADBEEF to r5, reserve r7, assert rst=0 mid-cycle → rd_data(r5)=0 and busy_vec=0 immediately, before any clock edge.
- Bypass: reg[3]=0x11, then in one cycle wr_en with r3=0x22 and rd_addr[0]=3 → rd_data[0]=0x22 that cycle, and 0x22 after the edge with wr_en=0.
- x0: write 0xFFFF_FFFF to r0 and reserve r0 → rd_data(r0)=0, busy_vec[0]=0, rd_busy=0.
- Scoreboard: reserve r9 → next cycle busy_vec[9]=1 and rd_busy=1 on a port reading r9. Write r9 → rd_busy=0 that cycle with data bypassed, busy_vec[9]=0 next cycle.
- Simultaneous: r4 busy, same cycle resv r4 and wr r4=0x55 → busy_vec[4]=1 next cycle, reg[4]=0x55. Then flush with resv r6 → busy_vec=0 next cycle.
- Multi-port (NRD=4, XLEN=64, NREGS=16): four ports read distinct registers, one of them bypassed → each port returns the correct 64-bit value independently.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its busy scoreboard.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write flags. Register 0 never becomes busy.
// Update priority per register: flush, then reserve, then writeback clear.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resv_en,
  input  logic [AW-1:0]    resv_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_busy
    logic busy_q;
    logic busy_d;

    // A new reservation supersedes a completing producer, so reserve beats the clear.
    always_comb begin
      busy_d = busy_q;
      if (flush) begin
        busy_d = 1'b0;
      end else if (resv_en && (resv_addr == AW'(r))) begin
        busy_d = 1'b1;
      end else if (wr_en && (wr_addr == AW'(r))) begin
        busy_d = 1'b0;
      end
    end

    // Busy flag register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        busy_q <= 1'b0;
      end else begin
        busy_q <= busy_d;
      end
    end

    assign busy_vec[r] = busy_q;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with same-cycle write bypass and a
// pending-write scoreboard. Register 0 reads as zero and is never stored.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic              resv_en,
  input  logic [AW-1:0]     resv_addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              flush,
  output logic [NREGS-1:0]  busy_vec
);

  // Read-side view of storage; entry 0 is a constant.
  logic [XLEN-1:0] rf_view [NREGS];

  assign rf_view[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [XLEN-1:0] reg_q;
    logic [XLEN-1:0] reg_d;

    // Next value: take writeback data when this register is the destination.
    always_comb begin
      reg_d = reg_q;
      if (wr_en && (wr_addr == AW'(r))) begin
        reg_d = wr_data;
      end
    end

    // Storage word, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rf_view[r] = reg_q;
  end

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  // A producer completing this cycle is forwarded rather than stalled,
  // so the bypass hit also masks the busy flag.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp_hit;

    assign addr    = rd_addr[p*AW +: AW];
    assign byp_hit = wr_en && (wr_addr == addr) && (addr != '0);

    assign rd_data[p*XLEN +: XLEN] = byp_hit ? wr_data : rf_view[addr];
    assign rd_busy[p]              = busy_vec[addr] & ~byp_hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default configuration checked against a behavioural
// model every cycle, plus a wide 4-port instance checked with literals.
module tb_reg_file_sb;
  import regfile_pkg::*;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A: defaults (XLEN=32, NREGS=32, NRD=2)
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_resv_en = 1'b0;
  reg_addr_t   a_resv_addr = '0;
  logic        a_wr_en = 1'b0;
  reg_addr_t   a_wr_addr = '0;
  data_t       a_wr_data = '0;
  logic        a_flush = 1'b0;
  logic [31:0] a_busy_vec;

  reg_file_sb dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .resv_en(a_resv_en), .resv_addr(a_resv_addr),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .flush(a_flush), .busy_vec(a_busy_vec)
  );

  // ---------------- instance B: XLEN=64, NREGS=16, NRD=4
  logic [15:0]  b_rd_addr = '0;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_resv_en = 1'b0;
  logic [3:0]   b_resv_addr = '0;
  logic         b_wr_en = 1'b0;
  logic [3:0]   b_wr_addr = '0;
  logic [63:0]  b_wr_data = '0;
  logic         b_flush = 1'b0;
  logic [15:0]  b_busy_vec;

  reg_file_sb #(.XLEN(64), .NREGS(16), .NRD(4)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .resv_en(b_resv_en), .resv_addr(b_resv_addr),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .flush(b_flush), .busy_vec(b_busy_vec)
  );

  // ---------------- behavioural model of instance A
  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (a_wr_en && a_wr_addr != 0) m_reg[a_wr_addr] = a_wr_data;
      if (a_flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (a_wr_en)   m_busy[a_wr_addr]   = 1'b0;
        if (a_resv_en) m_busy[a_resv_addr] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of instance A against the model, on the falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_vec;
    for (int p = 0; p < 2; p++) begin
      logic [4:0]  ad;
      logic [31:0] ed;
      logic        eb;
      logic        fwd;
      ad  = a_rd_addr[p*5 +: 5];
      fwd = a_wr_en && a_wr_addr == ad && ad != 0;
      ed  = (ad == 0) ? 32'h0 : (fwd ? a_wr_data : m_reg[ad]);
      eb  = (ad != 0) && m_busy[ad] && !fwd;
      chk($sformatf("model rd_data[%0d]", p), {32'h0, a_rd_data[p*32 +: 32]}, {32'h0, ed});
      chk($sformatf("model rd_busy[%0d]", p), {63'h0, a_rd_busy[p]}, {63'h0, eb});
    end
    for (int i = 0; i < 32; i++) exp_vec[i] = m_busy[i];
    chk("model busy_vec", {32'h0, a_busy_vec}, {32'h0, exp_vec});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en = 1'b0; a_resv_en = 1'b0; a_flush = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] ad, input logic [31:0] d);
    a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d;
  endtask

  task automatic resv_a(input logic [4:0] ad);
    a_resv_en = 1'b1; a_resv_addr = ad;
  endtask

  task automatic wr_b(input logic [3:0] ad, input logic [63:0] d);
    b_wr_en = 1'b1; b_wr_addr = ad; b_wr_data = d;
    step();
    b_wr_en = 1'b0;
  endtask

  initial begin
    // in reset
    #3;
    chk("reset rd_data", {a_rd_data[31:0], a_rd_data[63:32]}, 64'h0);
    chk("reset busy_vec", {32'h0, a_busy_vec}, 64'h0);
    step();
    rst = 1'b1;
    step();

    // mid-cycle asynchronous reset
    wr_a(5'd5, 32'hDEADBEEF); resv_a(5'd7);
    step();
    idle_a(); a_rd_addr = {5'd7, 5'd5};
    #1;
    chk("pre-reset r5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    chk("pre-reset busy r7", {63'h0, a_busy_vec[7]}, 64'h1);
    chk("pre-reset rd_busy r7", {63'h0, a_rd_busy[1]}, 64'h1);
    rst = 1'b0;
    #1;
    chk("async reset r5", {32'h0, a_rd_data[31:0]}, 64'h0);
    chk("async reset busy_vec", {32'h0, a_busy_vec}, 64'h0);
    step();
    rst = 1'b1;
    step();

    // bypass
    wr_a(5'd3, 32'h11);
    step();
    wr_a(5'd3, 32'h22); a_rd_addr = {5'd3, 5'd3};
    #1;
    chk("bypass same cycle p0", {32'h0, a_rd_data[31:0]}, 64'h22);
    chk("bypass same cycle p1", {32'h0, a_rd_data[63:32]}, 64'h22);
    step();
    idle_a();
    #1;
    chk("stored after write", {32'h0, a_rd_data[31:0]}, 64'h22);

    // register zero
    wr_a(5'd0, 32'hFFFF_FFFF); resv_a(5'd0); a_rd_addr = {5'd0, 5'd0};
    #1;
    chk("x0 no bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
    step();
    idle_a();
    #1;
    chk("x0 rd_data", {32'h0, a_rd_data[31:0]}, 64'h0);
    chk("x0 busy bit", {63'h0, a_busy_vec[0]}, 64'h0);
    chk("x0 rd_busy", {62'h0, a_rd_busy}, 64'h0);

    // scoreboard reserve and clear
    resv_a(5'd9); a_rd_addr = {5'd9, 5'd0};
    #1;
    chk("resv cycle not busy", {63'h0, a_rd_busy[1]}, 64'h0);
    step();
    idle_a();
    #1;
    chk("r9 busy_vec", {63'h0, a_busy_vec[9]}, 64'h1);
    chk("r9 rd_busy", {63'h0, a_rd_busy[1]}, 64'h1);
    wr_a(5'd9, 32'h99);
    #1;
    chk("r9 producer bypass busy", {63'h0, a_rd_busy[1]}, 64'h0);
    chk("r9 producer bypass data", {32'h0, a_rd_data[63:32]}, 64'h99);
    step();
    idle_a();
    #1;
    chk("r9 cleared", {63'h0, a_busy_vec[9]}, 64'h0);

    // reserve and write same register, then flush beats reserve
    resv_a(5'd4);
    step();
    resv_a(5'd4); wr_a(5'd4, 32'h55);
    step();
    idle_a(); a_rd_addr = {5'd0, 5'd4};
    #1;
    chk("r4 stays busy", {63'h0, a_busy_vec[4]}, 64'h1);
    chk("r4 data", {32'h0, a_rd_data[31:0]}, 64'h55);
    a_flush = 1'b1; resv_a(5'd6); wr_a(5'd8, 32'h88);
    step();
    idle_a(); a_rd_addr = {5'd8, 5'd6};
    #1;
    chk("flush clears all", {32'h0, a_busy_vec}, 64'h0);
    chk("flush keeps write", {32'h0, a_rd_data[63:32]}, 64'h88);

    // random traffic, checked by the model each cycle
    for (int i = 0; i < 200; i++) begin
      a_wr_en     = 1'($urandom_range(0, 1));
      a_wr_addr   = 5'($urandom_range(0, 7));
      a_wr_data   = $urandom;
      a_resv_en   = 1'($urandom_range(0, 1));
      a_resv_addr = 5'($urandom_range(0, 7));
      a_flush     = ($urandom_range(0, 15) == 0);
      a_rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end
    idle_a();

    // wide four-port instance
    wr_b(4'd1, 64'h1111_2222_3333_4444);
    wr_b(4'd2, 64'hAAAA_BBBB_CCCC_DDDD);
    wr_b(4'd3, 64'h0123_4567_89AB_CDEF);
    wr_b(4'd4, 64'h5555_5555_5555_5555);
    b_wr_en = 1'b1; b_wr_addr = 4'd4; b_wr_data = 64'hFEDC_BA98_7654_3210;
    b_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    chk("wide p0", b_rd_data[63:0],    64'h1111_2222_3333_4444);
    chk("wide p1", b_rd_data[127:64],  64'hAAAA_BBBB_CCCC_DDDD);
    chk("wide p2", b_rd_data[191:128], 64'h0123_4567_89AB_CDEF);
    chk("wide p3 bypass", b_rd_data[255:192], 64'hFEDC_BA98_7654_3210);
    step();
    b_wr_en = 1'b0; b_resv_en = 1'b1; b_resv_addr = 4'd15;
    b_rd_addr = {4'd15, 4'd0, 4'd4, 4'd4};
    step();
    b_resv_en = 1'b0;
    #1;
    chk("wide stored p0", b_rd_data[63:0], 64'hFEDC_BA98_7654_3210);
    chk("wide old value gone p1", b_rd_data[127:64], 64'hFEDC_BA98_7654_3210);
    chk("wide x0 p2", b_rd_data[191:128], 64'h0);
    chk("wide rd_busy", {60'h0, b_rd_busy}, 64'h8);
    chk("wide busy_vec", {48'h0, b_busy_vec}, 64'h8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
